plab2_mem_dmem_responder: RTL

- Single-port, word-addressed data-memory responder for the pipelined processor's data-memory port; it services the processor's load/store requests with val/rdy handshakes on both request and response.
- One transaction is outstanding at a time, with a parameterised response latency.
- Memory is split into two security partitions selected by the index MSB. Each access is checked against the `domain` input; a violating access returns an error response and never touches storage.

---
 rtl/plab2_mem_dmem_responder.sv | 119 +++++++++++
 1 files changed

// File: rtl/plab2_mem_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : plab2_mem_dmem_responder
// Function : Partitioned data-memory responder, one outstanding val/rdy txn.
// Revision : 1.0
// ============================================================================
module plab2_mem_dmem_responder #(
    parameter int          p_num_entries = 256,
    parameter logic [31:0] p_base_addr   = 32'h00002000,
    parameter int          p_latency     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        domain,
    input  logic        req_val,
    output logic        req_rdy,
    input  logic        req_type,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_data,
    output logic        resp_val,
    input  logic        resp_rdy,
    output logic        resp_type,
    output logic [31:0] resp_data,
    output logic        resp_err
);
    localparam int          c_AW      = $clog2(p_num_entries);
    localparam int          c_LAT     = (p_latency < 1) ? 1 : p_latency;
    localparam int          c_CNT_W   = (c_LAT > 1) ? $clog2(c_LAT) : 1;
    localparam logic [c_CNT_W-1:0] c_LOAD = c_CNT_W'(c_LAT - 1);
    localparam logic [31:0] c_SPAN    = 32'(4 * p_num_entries);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_CNT_W-1:0]   w_cnt_nxt;
    logic [31:0]          r_mem [p_num_entries];
    logic                 r_type;
    logic                 r_err;
    logic [31:0]          r_data;
    logic [31:0]          w_off;
    logic [c_AW-1:0]      w_idx;
    logic                 w_err;
    logic                 w_accept;

    // Wrap-around offset makes addresses below the base land far out of range.
    assign w_off    = req_addr - p_base_addr;
    assign w_idx    = w_off[c_AW+1:2];
    assign w_err    = (req_addr[1:0] != 2'b00) | (w_off >= c_SPAN)
                    | (w_idx[c_AW-1] != domain);
    assign req_rdy  = (r_state == ST_IDLE) & reset;
    assign w_accept = req_val & req_rdy;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_cnt_nxt   = c_LOAD;
                    w_state_nxt = (c_LOAD != '0) ? ST_DELAY : ST_RESP;
                end
            end
            ST_DELAY: begin
                w_cnt_nxt = r_cnt - 1'b1;
                if (r_cnt <= c_CNT_W'(1)) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (resp_rdy) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Read captures the pre-write array value; errors and writes return zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_type <= 1'b0;
            r_err  <= 1'b0;
            r_data <= '0;
        end else if (w_accept) begin
            r_type <= req_type;
            r_err  <= w_err;
            r_data <= (!req_type && !w_err) ? r_mem[w_idx] : 32'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept && req_type && !w_err) begin
            r_mem[w_idx] <= req_data;
        end
    end

    assign resp_val  = (r_state == ST_RESP);
    assign resp_type = r_type;
    assign resp_data = r_data;
    assign resp_err  = r_err;

endmodule
`default_nettype wire
